gstmcu_mem_sched: RTL and testbench
===================================

Name: gstmcu_mem_sched

Overview:
- DRAM slot scheduler for the GSTMCU memory path.
- Divides clk32 into 4 MHz memory slots and alternates even (video/refresh) and odd (CPU/DMA) slots.
- Issues increment strobes to the video and DMA address counter chains and runs the 68000 bus-request handshake for DMA.
- Generates RAS/CAS timing for each granted slot.

Parameters:
REFRESH_INTERVAL, 64, slot pairs between refresh requests (range 2..255)
DMA_BURST_MAX, 8, max consecutive odd slots a DMA owner keeps before forced release (range 1..15)

Ports:
clk32  in  1  32 MHz system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
de  in  1  video display enable; video fetch only honoured when 1
vid_req  in  1  shifter wants a word this slot
dma_req  in  1  DMA channel wants a word
cpu_as  in  1  CPU address strobe active (1 = CPU cycle in progress)
bg  in  1  CPU bus grant (active-high here)
br  out  1  bus request to CPU
bgack  out  1  bus grant acknowledge (DMA owns bus)
slot_vid  out  1  current slot granted to video
slot_ref  out  1  current slot is refresh
slot_cpu  out  1  current slot granted to CPU
slot_dma  out  1  current slot granted to DMA
vid_inc  out  1  one-clk pulse: advance video address counter
dma_inc  out  1  one-clk pulse: advance DMA address counter
ras_n  out  1  DRAM RAS, active low
cas_n  out  1  DRAM CAS, active low
ph  out  3  slot phase 0..7
ref_overrun  out  1  sticky: a refresh request arrived while one was still pending

Behaviour:
- Reset state:
  - ph=0, parity=even, all slot_* = 0.
  - br=0, bgack=0, vid_inc=0, dma_inc=0, ras_n=1, cas_n=1.
  - Refresh counter=0, pending=0, ref_overrun=0, DMA FSM=IDLE, burst count=0.
  - The first slot after reset is an idle even slot.
- Slot timing:
  - ph increments every clk32 and wraps 7->0.
  - Parity toggles at each wrap.
  - The grant decision is made from inputs sampled at ph=7. slot_* registers load at the edge where ph becomes 0 and hold for 8 clocks.
  - Exactly zero or one slot_* is high at any time.
- Even slot priority:
  - vid_req&de -> vid.
  - Else refresh pending -> ref.
  - Else idle (no grant).
- Odd slot:
  - DMA FSM in OWN and dma_req -> dma.
  - Else -> cpu.
  - cpu is granted even when cpu_as=0 (the slot is simply unused).
- RAS/CAS:
  - For any granted slot, ras_n=0 for ph 1..5.
  - cas_n=0 for ph 3..5 on vid, cpu and dma slots only. Refresh is RAS-only (cas_n stays 1).
  - Idle slot: both stay 1.
- Counter strobes: vid_inc=1 at ph=7 of a vid slot; dma_inc=1 at ph=7 of a dma slot. Each strobe is exactly one clk32 wide.
- Refresh:
  - The counter increments once per slot pair, at the odd->even wrap.
  - On reaching REFRESH_INTERVAL-1 the counter wraps to 0 and sets pending.
  - Pending clears at the ph=0 edge that grants slot_ref.
  - If the counter wraps while pending is already set: pending stays 1 (no queue) and ref_overrun is set (cleared only by reset).
  - Refresh never preempts video.
- DMA FSM (transitions on any clk32 edge unless noted):
  - IDLE: dma_req=1 and cooldown clear -> REQ.
  - REQ: br=1. When bg=1 and cpu_as=0 -> OWN; br=0 and bgack=1 in the same cycle. If dma_req drops first -> IDLE with br=0.
  - OWN: bgack=1. Burst count increments on each dma slot grant.
  - Release -> IDLE with bgack=0 and cooldown set, when either:
    - dma_req=0 at an odd-slot ph=7, or
    - the burst count reaches DMA_BURST_MAX.
  - Cooldown clears after the next cpu-granted odd slot completes. This guarantees CPU at least one odd slot between bursts.
- Simultaneous events:
  - dma_req drop and burst max in the same cycle -> a single release.
  - vid_req with de=0 is ignored, so refresh or idle is used.
- Reset asserted mid-operation (including mid-DMA or mid-RAS): all outputs return to reset values on the next clock edge.

Test Plan:
- Reset, then run 32 clks with no requests -> slots alternate idle/cpu; ras_n low ph1..5 on cpu slots only; no inc pulses.
- de=1, vid_req=1 constantly -> every even slot is slot_vid; vid_inc one-clk pulse at ph=7 every 16 clks; cas_n low ph3..5.
- REFRESH_INTERVAL=4, de=0 -> slot_ref on the even slot after 4 slot pairs, ras_n low, cas_n high. With vid_req&de held for 8 pairs -> ref_overrun=1, ref granted on the first even slot after vid_req drops.
- dma_req=1, bg=0 -> br=1 held, odd slots stay cpu. Then bg=1 with cpu_as=1 -> stays REQ. Then cpu_as=0 -> bgack=1, br=0, following odd slots are dma with dma_inc pulses.
- DMA_BURST_MAX=3, dma_req held -> exactly 3 dma slots, bgack drops, one cpu odd slot, then br reasserts.
- Reset pulsed at ph=4 of a dma slot with ras_n=0 -> next cycle ras_n=1, bgack=0, ph=0, all slot_* = 0.

Source files
------------

// File: rtl/gstmcu_mem_sched.sv
// GSTMCU DRAM slot scheduler: 8-clock memory slots alternating video/refresh and CPU/DMA,
// with the 68000 bus-request handshake for DMA and RAS/CAS generation per granted slot.
module gstmcu_mem_sched #(
    parameter int REFRESH_INTERVAL = 64,
    parameter int DMA_BURST_MAX    = 8
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       de,
    input  logic       vid_req,
    input  logic       dma_req,
    input  logic       cpu_as,
    input  logic       bg,
    output logic       br,
    output logic       bgack,
    output logic       slot_vid,
    output logic       slot_ref,
    output logic       slot_cpu,
    output logic       slot_dma,
    output logic       vid_inc,
    output logic       dma_inc,
    output logic       ras_n,
    output logic       cas_n,
    output logic [2:0] ph,
    output logic       ref_overrun
);

    localparam logic [7:0] REF_LAST   = 8'(REFRESH_INTERVAL - 1);
    localparam logic [3:0] BURST_LAST = 4'(DMA_BURST_MAX);

    typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_OWN} dma_state_e;

    logic [2:0] ph_q, ph_d;
    logic       odd_q, odd_d;
    logic       vid_q, vid_d, ref_q, ref_d, cpu_q, cpu_d, dma_q, dma_d;
    logic [7:0] ref_cnt_q, ref_cnt_d;
    logic       ref_pend_q, ref_pend_d;
    logic       ref_ovr_q, ref_ovr_d;
    dma_state_e st_q, st_d;
    logic [3:0] burst_q, burst_d;
    logic       cool_q, cool_d;
    logic       slot_end, ref_wrap, grant_ref;

    always_ff @(posedge clk32) begin
        if (reset) begin
            ph_q       <= 3'd0;
            odd_q      <= 1'b0;
            vid_q      <= 1'b0;
            ref_q      <= 1'b0;
            cpu_q      <= 1'b0;
            dma_q      <= 1'b0;
            ref_cnt_q  <= 8'd0;
            ref_pend_q <= 1'b0;
            ref_ovr_q  <= 1'b0;
            st_q       <= DMA_IDLE;
            burst_q    <= 4'd0;
            cool_q     <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            odd_q      <= odd_d;
            vid_q      <= vid_d;
            ref_q      <= ref_d;
            cpu_q      <= cpu_d;
            dma_q      <= dma_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_ovr_q  <= ref_ovr_d;
            st_q       <= st_d;
            burst_q    <= burst_d;
            cool_q     <= cool_d;
        end
    end

    always_comb begin
        ph_d       = ph_q + 3'd1;
        odd_d      = odd_q;
        vid_d      = vid_q;
        ref_d      = ref_q;
        cpu_d      = cpu_q;
        dma_d      = dma_q;
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        ref_ovr_d  = ref_ovr_q;
        st_d       = st_q;
        burst_d    = burst_q;
        cool_d     = cool_q;
        grant_ref  = 1'b0;
        slot_end   = (ph_q == 3'd7);
        // A refresh tick landing on this very wrap may be serviced by the slot it opens.
        ref_wrap   = slot_end && odd_q && (ref_cnt_q == REF_LAST);

        if (slot_end) begin
            odd_d = ~odd_q;
            {vid_d, ref_d, cpu_d, dma_d} = 4'b0000;
            if (odd_q) begin
                if (vid_req && de) begin
                    vid_d = 1'b1;
                end else if (ref_pend_q || ref_wrap) begin
                    ref_d     = 1'b1;
                    grant_ref = 1'b1;
                end
                ref_cnt_d = ref_wrap ? 8'd0 : ref_cnt_q + 8'd1;
            end else if (st_q == DMA_OWN && dma_req) begin
                dma_d   = 1'b1;
                burst_d = burst_q + 4'd1;
            end else begin
                cpu_d = 1'b1;
            end
            if (cpu_q) begin
                cool_d = 1'b0;
            end
        end

        if (ref_wrap) begin
            if (ref_pend_q) begin
                ref_ovr_d = 1'b1;
            end
            ref_pend_d = ref_pend_q || !grant_ref;
        end else if (grant_ref) begin
            ref_pend_d = 1'b0;
        end

        // Release waits for the end of an odd slot so the last DMA access finishes under bgack.
        case (st_q)
            DMA_IDLE: if (dma_req && !cool_q) st_d = DMA_REQ;
            DMA_REQ: begin
                if (!dma_req) begin
                    st_d = DMA_IDLE;
                end else if (bg && !cpu_as) begin
                    st_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (slot_end && odd_q && (!dma_req || burst_q >= BURST_LAST)) begin
                    st_d    = DMA_IDLE;
                    burst_d = 4'd0;
                    cool_d  = 1'b1;
                end
            end
            default: st_d = DMA_IDLE;
        endcase
    end

    assign ph          = ph_q;
    assign slot_vid    = vid_q;
    assign slot_ref    = ref_q;
    assign slot_cpu    = cpu_q;
    assign slot_dma    = dma_q;
    assign br          = (st_q == DMA_REQ);
    assign bgack       = (st_q == DMA_OWN);
    assign ras_n       = !((vid_q || ref_q || cpu_q || dma_q) && ph_q >= 3'd1 && ph_q <= 3'd5);
    assign cas_n       = !((vid_q || cpu_q || dma_q) && ph_q >= 3'd3 && ph_q <= 3'd5);
    assign vid_inc     = vid_q && (ph_q == 3'd7);
    assign dma_inc     = dma_q && (ph_q == 3'd7);
    assign ref_overrun = ref_ovr_q;

endmodule

// File: tb/tb_gstmcu_mem_sched.sv
// Directed self-checking bench for gstmcu_mem_sched (REFRESH_INTERVAL=4, DMA_BURST_MAX=3).
module tb_gstmcu_mem_sched;

    localparam int K_IDLE = 0;
    localparam int K_VID  = 1;
    localparam int K_REF  = 2;
    localparam int K_CPU  = 3;
    localparam int K_DMA  = 4;

    logic       clk32 = 1'b0;
    logic       reset = 1'b0;
    logic       de = 1'b0, vid_req = 1'b0, dma_req = 1'b0, cpu_as = 1'b0, bg = 1'b0;
    logic       br, bgack, slot_vid, slot_ref, slot_cpu, slot_dma;
    logic       vid_inc, dma_inc, ras_n, cas_n, ref_overrun;
    logic [2:0] ph;

    int checks   = 0;
    int failures = 0;

    gstmcu_mem_sched #(.REFRESH_INTERVAL(4), .DMA_BURST_MAX(3)) dut (
        .clk32(clk32), .reset(reset), .de(de), .vid_req(vid_req), .dma_req(dma_req),
        .cpu_as(cpu_as), .bg(bg), .br(br), .bgack(bgack), .slot_vid(slot_vid),
        .slot_ref(slot_ref), .slot_cpu(slot_cpu), .slot_dma(slot_dma), .vid_inc(vid_inc),
        .dma_inc(dma_inc), .ras_n(ras_n), .cas_n(cas_n), .ph(ph), .ref_overrun(ref_overrun)
    );

    always #5 clk32 = ~clk32;

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Layout: {ph, vid, ref, cpu, dma, ras_n, cas_n, vid_inc, dma_inc, br, bgack, overrun}
    function automatic logic [13:0] pack_obs();
        return {ph, slot_vid, slot_ref, slot_cpu, slot_dma, ras_n, cas_n,
                vid_inc, dma_inc, br, bgack, ref_overrun};
    endfunction

    function automatic logic [13:0] mk_exp(input int kind, input int p, input bit ebr,
                                           input bit ebgack, input bit eovr);
        bit ras, cas;
        ras = (kind != K_IDLE) && p >= 1 && p <= 5;
        cas = (kind == K_VID || kind == K_CPU || kind == K_DMA) && p >= 3 && p <= 5;
        return {3'(p), kind == K_VID, kind == K_REF, kind == K_CPU, kind == K_DMA, !ras, !cas,
                kind == K_VID && p == 7, kind == K_DMA && p == 7, ebr, ebgack, eovr};
    endfunction

    task automatic test_reset();
        logic [13:0] obs, exp;
        de = 1'b1; vid_req = 1'b1; dma_req = 1'b1; bg = 1'b1; cpu_as = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        obs = pack_obs();
        exp = mk_exp(K_IDLE, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reset_state got=%b exp=%b", obs, exp);
        end
        reset = 1'b0;
        de = 1'b0; vid_req = 1'b0; dma_req = 1'b0; bg = 1'b0;
    endtask

    task automatic test_idle_cpu();
        logic [13:0] obs, exp;
        int s, kind;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            s = c / 8;
            kind = (s % 2 == 1) ? K_CPU : K_IDLE;
            obs = pack_obs();
            exp = mk_exp(kind, c % 8, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL idle_cpu cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_video();
        logic [13:0] obs, exp;
        int s, kind;
        de = 1'b1; vid_req = 1'b1;
        do_reset();
        for (int c = 0; c < 48; c++) begin
            s = c / 8;
            kind = (s % 2 == 1) ? K_CPU : ((s == 0) ? K_IDLE : K_VID);
            obs = pack_obs();
            exp = mk_exp(kind, c % 8, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL video cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            tick();
        end
        de = 1'b0; vid_req = 1'b0;
    endtask

    task automatic test_refresh();
        logic [13:0] obs, exp;
        int s, kind;
        vid_req = 1'b1;
        do_reset();
        for (int c = 0; c < 96; c++) begin
            s = c / 8;
            kind = (s % 2 == 1) ? K_CPU : ((s == 8) ? K_REF : K_IDLE);
            obs = pack_obs();
            exp = mk_exp(kind, c % 8, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL refresh cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            tick();
        end
        vid_req = 1'b0;
    endtask

    task automatic test_overrun();
        logic [13:0] obs, exp;
        int s, kind;
        de = 1'b1; vid_req = 1'b1;
        do_reset();
        for (int c = 0; c < 168; c++) begin
            s = c / 8;
            if (s % 2 == 1)               kind = K_CPU;
            else if (s >= 2 && s <= 16)   kind = K_VID;
            else if (s == 18)             kind = K_REF;
            else                          kind = K_IDLE;
            obs = pack_obs();
            exp = mk_exp(kind, c % 8, 1'b0, 1'b0, c >= 128);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL overrun cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 128) vid_req = 1'b0;
            tick();
        end
        de = 1'b0;
    endtask

    task automatic test_dma_handshake();
        logic [13:0] obs, exp;
        int s, kind;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            s = c / 8;
            if (s == 7 || s == 9)  kind = K_DMA;
            else if (s == 8)       kind = K_REF;
            else if (s % 2 == 1)   kind = K_CPU;
            else                   kind = K_IDLE;
            obs = pack_obs();
            exp = mk_exp(kind, c % 8, c >= 1 && c <= 48, c >= 49, 1'b0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL dma_handshake cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 0)  begin dma_req = 1'b1; cpu_as = 1'b1; end
            if (c == 40) bg = 1'b1;
            if (c == 48) cpu_as = 1'b0;
            tick();
        end
        dma_req = 1'b0; bg = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [13:0] obs, exp;
        int s, kind;
        dma_req = 1'b1; bg = 1'b1; cpu_as = 1'b0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            s = c / 8;
            if (s == 1 || s == 3 || s == 5 || s == 9) kind = K_DMA;
            else if (s == 7)                          kind = K_CPU;
            else if (s == 8)                          kind = K_REF;
            else                                      kind = K_IDLE;
            obs = pack_obs();
            exp = mk_exp(kind, c % 8, c == 1 || c == 65,
                         (c >= 2 && c <= 47) || c >= 66, 1'b0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL burst_max cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            tick();
        end
        dma_req = 1'b0; bg = 1'b0;
    endtask

    task automatic test_reset_mid_dma();
        logic [13:0] obs, exp;
        dma_req = 1'b1; bg = 1'b1; cpu_as = 1'b0;
        do_reset();
        repeat (12) tick();
        checks++;
        if (ras_n !== 1'b0 || slot_dma !== 1'b1 || bgack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_dma_setup got ras_n=%b dma=%b bgack=%b exp 0 1 1",
                     ras_n, slot_dma, bgack);
        end
        reset = 1'b1;
        tick();
        obs = pack_obs();
        exp = mk_exp(K_IDLE, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL reset_mid_dma got=%b exp=%b", obs, exp);
        end
        reset = 1'b0;
        dma_req = 1'b0; bg = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_cpu();
        test_video();
        test_refresh();
        test_overrun();
        test_dma_handshake();
        test_back_to_back();
        test_reset_mid_dma();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
